id_ex_pipeline_register: RTL and testbench
==========================================

// Module: id_ex_pipeline_register
// PURPOSE
//  ID/EX pipeline stage register for the pipelined MIPS core; sits directly downstream of the control unit.
//  Captures the decode-stage control word, operands and register fields, and presents them to EX.
//  Detects load-use hazards: stalls PC and IF/ID, and injects one bubble into EX.
//  Squashes the decode slot on a taken-branch flush.
// PARAMETERS
//  DATA_WIDTH  32  width of operands, immediate and PC+4
//  REG_W       5   register-address width
//  CTRL_W      11  control-word width
//  CNT_W       16  stall performance-counter width
// PORTS
//  clk              in   1           rising-edge clock
//  reset            in   1           asynchronous, active-low reset
//  id_valid_i       in   1           ID slot holds a real instruction
//  id_ctrl_i        in   CTRL_W      {RegDst,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,BranchNE,BranchEQ,ALUOp[2:0]}
//  id_rs_i/id_rt_i/id_rd_i  in  REG_W  source/target/dest fields
//  id_uses_rt_i     in   1           rt is a source operand (R-type, branch, store)
//  id_rdata1_i/id_rdata2_i  in  DATA_WIDTH  register-file read data
//  id_imm_i         in   DATA_WIDTH  sign-extended immediate
//  id_pc4_i         in   DATA_WIDTH  PC+4 of the ID instruction
//  flush_i          in   1           squash ID slot (taken branch)
//  ex_valid_o       out  1           EX slot valid
//  ex_ctrl_o        out  CTRL_W      registered control word (all 0 when bubble)
//  ex_rdata1_o/ex_rdata2_o/ex_imm_o/ex_pc4_o  out  DATA_WIDTH  registered data
//  ex_rs_o/ex_rt_o  out  REG_W       registered source fields (for forwarding)
//  ex_dst_o         out  REG_W       RegDst ? rd : rt, resolved at capture
//  hazard_stall_o   out  1           combinational: hold PC and IF/ID this cycle
//  stall_cnt_o      out  CNT_W       saturating count of hazard-stall cycles
// BEHAVIOUR
//  - reset low (any time, async): all ex_* outputs = 0, ex_valid_o = 0, stall_cnt_o = 0.
//    Outputs stay 0 until the first rising edge after release.
//  - Hazard (combinational) = ex_valid_o & ex_ctrl_o.MemRead & id_valid_i & (ex_rt_o != 0)
//    & (ex_rt_o == id_rs_i | (id_uses_rt_i & ex_rt_o == id_rt_i)).
//  - hazard_stall_o = hazard & ~flush_i.
//  - Each rising edge, priority flush > hazard > normal:
//    flush_i=1: ex_valid_o<=0, ex_ctrl_o<=0; data fields captured, but are don't-care.
//    hazard: ex_valid_o<=0, ex_ctrl_o<=0 (bubble); stall_cnt_o += 1, saturating at 2^CNT_W-1.
//    normal: every field <= ID input; ex_valid_o<=id_valid_i.
//    id_valid_i=0 forces ex_ctrl_o<=0.
//  - Latency: one cycle ID->EX. A load-use stall lasts exactly one cycle, because the bubble clears ex_valid_o.
//  - Flush together with hazard: flush wins. No stall is asserted and the counter does not increment.
//  - Register $0 as load target never causes a stall.
//  - Stall counter holds at max; it is cleared only by reset.
//  - Unknown opcodes arrive as all-zero ctrl; they pass through as a valid no-op.
// STRUCTURE
//  - Shared header mips_pipe_defs.vh:
//    CTRL_W; bit-index constants (CTRL_REGDST=10 ... CTRL_ALUOP_LSB=0);
//    ALUOp codes (R=3'b111, ADDI=001, ANDI=010, ORI=011, LUI=100).
//  - One sub-module: load_use_hazard_unit (combinational compare, drives hazard).
//  - Register bank and counter live in the top module.
// TESTING
//  1 reset: reset=0 mid-run with ex_valid_o=1 -> all outputs 0 immediately (before next clk).
//  2 pass-through: ADDI ctrl 11'b0_101_00_00_001, rdata1=0x10, imm=0x5 -> next edge ex_ctrl_o same, ex_dst_o=rt.
//  3 load-use: EX lw (MemRead=1, rt=8), ID add rs=8 -> hazard_stall_o=1; next edge ex_ctrl_o=0, ex_valid_o=0, stall_cnt_o=1; following edge add captured.
//  4 no false stall: EX lw rt=0 with ID rs=0, or ID addi (uses_rt=0) with rt=8 -> hazard_stall_o=0.
//  5 flush+hazard: conditions of test 3 plus flush_i=1 -> hazard_stall_o=0; bubble; stall_cnt_o unchanged.
//  6 saturation: CNT_W=2, four consecutive load-use pairs -> stall_cnt_o stays 3.

Source files
------------

// File: rtl/id_ex_pipeline_register_pkg.sv
// Shared MIPS pipeline definitions: default widths, control-word bit positions and ALUOp codes.
package id_ex_pipeline_register_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_REG_W      = 5;
    localparam int unsigned DEF_CTRL_W     = 11;
    localparam int unsigned DEF_CNT_W      = 16;

    // Control word layout: {RegDst,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,BranchNE,BranchEQ,ALUOp[2:0]}
    localparam int unsigned CTRL_REGDST    = 10;
    localparam int unsigned CTRL_ALUSRC    = 9;
    localparam int unsigned CTRL_MEMTOREG  = 8;
    localparam int unsigned CTRL_REGWRITE  = 7;
    localparam int unsigned CTRL_MEMREAD   = 6;
    localparam int unsigned CTRL_MEMWRITE  = 5;
    localparam int unsigned CTRL_BRANCHNE  = 4;
    localparam int unsigned CTRL_BRANCHEQ  = 3;
    localparam int unsigned CTRL_ALUOP_MSB = 2;
    localparam int unsigned CTRL_ALUOP_LSB = 0;

    typedef enum logic [2:0] {
        ALUOP_ADD  = 3'b000,
        ALUOP_ADDI = 3'b001,
        ALUOP_ANDI = 3'b010,
        ALUOP_ORI  = 3'b011,
        ALUOP_LUI  = 3'b100,
        ALUOP_R    = 3'b111
    } aluOp_e;

endpackage

// File: rtl/id_ex_pipeline_register_load_use_hazard_unit.sv
// Load-use hazard detection: EX holds a load whose target is read by the instruction in ID.
module load_use_hazard_unit #(
    parameter int unsigned REG_W = 5
) (
    input  logic             exValid,
    input  logic             exMemRead,
    input  logic [REG_W-1:0] exRt,
    input  logic             idValid,
    input  logic [REG_W-1:0] idRs,
    input  logic [REG_W-1:0] idRt,
    input  logic             idUsesRt,
    output logic             hazard
);

    logic rsMatch;
    logic rtMatch;

    assign rsMatch = (exRt == idRs);
    assign rtMatch = idUsesRt & (exRt == idRt);

    // $0 is hardwired to zero, so a load into it never produces a dependency
    assign hazard = exValid & exMemRead & idValid & (exRt != '0) & (rsMatch | rtMatch);

endmodule

// File: rtl/id_ex_pipeline_register.sv
// ID/EX stage register: captures decode outputs for EX, inserts a bubble on load-use or flush,
// and counts hazard-stall cycles in a saturating counter.
module id_ex_pipeline_register
    import id_ex_pipeline_register_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned REG_W      = DEF_REG_W,
    parameter int unsigned CTRL_W     = DEF_CTRL_W,
    parameter int unsigned CNT_W      = DEF_CNT_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid_i,
    input  logic [CTRL_W-1:0]     id_ctrl_i,
    input  logic [REG_W-1:0]      id_rs_i,
    input  logic [REG_W-1:0]      id_rt_i,
    input  logic [REG_W-1:0]      id_rd_i,
    input  logic                  id_uses_rt_i,
    input  logic [DATA_WIDTH-1:0] id_rdata1_i,
    input  logic [DATA_WIDTH-1:0] id_rdata2_i,
    input  logic [DATA_WIDTH-1:0] id_imm_i,
    input  logic [DATA_WIDTH-1:0] id_pc4_i,
    input  logic                  flush_i,
    output logic                  ex_valid_o,
    output logic [CTRL_W-1:0]     ex_ctrl_o,
    output logic [DATA_WIDTH-1:0] ex_rdata1_o,
    output logic [DATA_WIDTH-1:0] ex_rdata2_o,
    output logic [DATA_WIDTH-1:0] ex_imm_o,
    output logic [DATA_WIDTH-1:0] ex_pc4_o,
    output logic [REG_W-1:0]      ex_rs_o,
    output logic [REG_W-1:0]      ex_rt_o,
    output logic [REG_W-1:0]      ex_dst_o,
    output logic                  hazard_stall_o,
    output logic [CNT_W-1:0]      stall_cnt_o
);

    localparam logic [CNT_W-1:0] CntMax = '1;

    logic hazard;
    logic bubble;

    load_use_hazard_unit #(
        .REG_W(REG_W)
    ) uHazard (
        .exValid  (ex_valid_o),
        .exMemRead(ex_ctrl_o[CTRL_MEMREAD]),
        .exRt     (ex_rt_o),
        .idValid  (id_valid_i),
        .idRs     (id_rs_i),
        .idRt     (id_rt_i),
        .idUsesRt (id_uses_rt_i),
        .hazard   (hazard)
    );

    // A flush squashes the dependent instruction, so no stall is needed
    assign hazard_stall_o = hazard & ~flush_i;
    assign bubble         = flush_i | hazard;

    // Data fields are captured every cycle; only valid/ctrl decide whether EX acts on them
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_valid_o  <= 1'b0;
            ex_ctrl_o   <= '0;
            ex_rdata1_o <= '0;
            ex_rdata2_o <= '0;
            ex_imm_o    <= '0;
            ex_pc4_o    <= '0;
            ex_rs_o     <= '0;
            ex_rt_o     <= '0;
            ex_dst_o    <= '0;
            stall_cnt_o <= '0;
        end else begin
            ex_rdata1_o <= id_rdata1_i;
            ex_rdata2_o <= id_rdata2_i;
            ex_imm_o    <= id_imm_i;
            ex_pc4_o    <= id_pc4_i;
            ex_rs_o     <= id_rs_i;
            ex_rt_o     <= id_rt_i;
            ex_dst_o    <= id_ctrl_i[CTRL_REGDST] ? id_rd_i : id_rt_i;
            if (bubble) begin
                ex_valid_o <= 1'b0;
                ex_ctrl_o  <= '0;
            end else begin
                ex_valid_o <= id_valid_i;
                ex_ctrl_o  <= id_valid_i ? id_ctrl_i : '0;
            end
            if (hazard_stall_o && (stall_cnt_o != CntMax)) begin
                stall_cnt_o <= stall_cnt_o + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_id_ex_pipeline_register.sv
// Directed bench for id_ex_pipeline_register: a reference model pushes expected EX state into a
// queue as each instruction is driven, and the entry is popped and checked after the clock edge.
module tb_id_ex_pipeline_register;

    localparam int unsigned DW = 32;
    localparam int unsigned RW = 5;
    localparam int unsigned CW = 11;
    localparam int unsigned NW = 2;

    localparam logic [CW-1:0] CtrlAddi = 11'b0_101_00_00_001;
    localparam logic [CW-1:0] CtrlLw   = 11'b0_111_10_00_000;
    localparam logic [CW-1:0] CtrlAdd  = 11'b1_001_00_00_111;

    typedef struct {
        logic          valid;
        logic [CW-1:0] ctrl;
        logic [RW-1:0] dst;
        logic [RW-1:0] rs;
        logic [RW-1:0] rt;
        logic [DW-1:0] r1;
        logic [DW-1:0] r2;
        logic [DW-1:0] imm;
        logic [DW-1:0] pc4;
        logic [NW-1:0] cnt;
        logic          chkData;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          idValid;
    logic [CW-1:0] idCtrl;
    logic [RW-1:0] idRs, idRt, idRd;
    logic          idUsesRt;
    logic [DW-1:0] idR1, idR2, idImm, idPc4;
    logic          flush;

    logic          exValid;
    logic [CW-1:0] exCtrl;
    logic [DW-1:0] exR1, exR2, exImm, exPc4;
    logic [RW-1:0] exRs, exRt, exDst;
    logic          stall;
    logic [NW-1:0] stallCnt;

    int checks = 0;
    int errors = 0;

    exp_t q[$];

    logic          mValid;
    logic [CW-1:0] mCtrl;
    logic [RW-1:0] mRt;
    logic [NW-1:0] mCnt;

    always #5 clk = ~clk;

    id_ex_pipeline_register #(
        .DATA_WIDTH(DW), .REG_W(RW), .CTRL_W(CW), .CNT_W(NW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .id_valid_i    (idValid),
        .id_ctrl_i     (idCtrl),
        .id_rs_i       (idRs),
        .id_rt_i       (idRt),
        .id_rd_i       (idRd),
        .id_uses_rt_i  (idUsesRt),
        .id_rdata1_i   (idR1),
        .id_rdata2_i   (idR2),
        .id_imm_i      (idImm),
        .id_pc4_i      (idPc4),
        .flush_i       (flush),
        .ex_valid_o    (exValid),
        .ex_ctrl_o     (exCtrl),
        .ex_rdata1_o   (exR1),
        .ex_rdata2_o   (exR2),
        .ex_imm_o      (exImm),
        .ex_pc4_o      (exPc4),
        .ex_rs_o       (exRs),
        .ex_rt_o       (exRt),
        .ex_dst_o      (exDst),
        .hazard_stall_o(stall),
        .stall_cnt_o   (stallCnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic setId(input logic v, input logic [CW-1:0] c, input logic [RW-1:0] rs,
                         input logic [RW-1:0] rt, input logic [RW-1:0] rd, input logic ur,
                         input logic [DW-1:0] r1, input logic [DW-1:0] imm);
        idValid  = v;
        idCtrl   = c;
        idRs     = rs;
        idRt     = rt;
        idRd     = rd;
        idUsesRt = ur;
        idR1     = r1;
        idR2     = r1 ^ 32'hA5A5_0F0F;
        idImm    = imm;
        idPc4    = idPc4 + 32'd4;
    endtask

    // One clock: check the combinational stall, predict EX state, clock, compare
    task automatic cycle();
        exp_t e;
        exp_t g;
        logic expHaz;
        #1;
        expHaz = mValid && mCtrl[6] && idValid && (mRt != 5'd0) &&
                 ((mRt == idRs) || (idUsesRt && (mRt == idRt)));
        chk("hazard_stall", 64'(stall), 64'(expHaz && !flush));
        e.chkData = !(flush || expHaz);
        e.valid   = e.chkData ? idValid : 1'b0;
        e.ctrl    = (e.chkData && idValid) ? idCtrl : '0;
        e.cnt     = (expHaz && !flush && (mCnt != 2'd3)) ? mCnt + 2'd1 : mCnt;
        e.dst     = idCtrl[10] ? idRd : idRt;
        e.rs      = idRs;
        e.rt      = idRt;
        e.r1      = idR1;
        e.r2      = idR2;
        e.imm     = idImm;
        e.pc4     = idPc4;
        q.push_back(e);
        @(posedge clk);
        #1;
        g = q.pop_front();
        chk("ex_valid", 64'(exValid), 64'(g.valid));
        chk("ex_ctrl", 64'(exCtrl), 64'(g.ctrl));
        chk("stall_cnt", 64'(stallCnt), 64'(g.cnt));
        if (g.chkData) begin
            chk("ex_dst", 64'(exDst), 64'(g.dst));
            chk("ex_rs", 64'(exRs), 64'(g.rs));
            chk("ex_rt", 64'(exRt), 64'(g.rt));
            chk("ex_rdata1", 64'(exR1), 64'(g.r1));
            chk("ex_rdata2", 64'(exR2), 64'(g.r2));
            chk("ex_imm", 64'(exImm), 64'(g.imm));
            chk("ex_pc4", 64'(exPc4), 64'(g.pc4));
        end
        mValid = g.valid;
        mCtrl  = g.ctrl;
        mRt    = g.rt;
        mCnt   = g.cnt;
        @(negedge clk);
    endtask

    task automatic chkAllZero(input string tag);
        chk({tag, "_valid"}, 64'(exValid), 64'd0);
        chk({tag, "_ctrl"}, 64'(exCtrl), 64'd0);
        chk({tag, "_rdata1"}, 64'(exR1), 64'd0);
        chk({tag, "_rdata2"}, 64'(exR2), 64'd0);
        chk({tag, "_imm"}, 64'(exImm), 64'd0);
        chk({tag, "_pc4"}, 64'(exPc4), 64'd0);
        chk({tag, "_rs_rt_dst"}, 64'({exRs, exRt, exDst}), 64'd0);
        chk({tag, "_cnt"}, 64'(stallCnt), 64'd0);
        chk({tag, "_stall"}, 64'(stall), 64'd0);
    endtask

    initial begin
        reset = 1'b0;
        flush = 1'b0;
        idPc4 = 32'h0040_0000;
        setId(1'b0, '0, '0, '0, '0, 1'b0, '0, '0);
        mValid = 1'b0; mCtrl = '0; mRt = '0; mCnt = '0;
        #2;
        chkAllZero("reset_init");
        @(negedge clk);
        reset = 1'b1;

        // ADDI pass-through: dst resolves to rt
        setId(1'b1, CtrlAddi, 5'd1, 5'd9, 5'd3, 1'b0, 32'h10, 32'h5);
        cycle();

        // Load-use: lw rt=8 then add rs=8 -> one bubble, then add captured
        setId(1'b1, CtrlLw, 5'd2, 5'd8, 5'd0, 1'b0, 32'h100, 32'h4);
        cycle();
        setId(1'b1, CtrlAdd, 5'd8, 5'd2, 5'd4, 1'b1, 32'h77, 32'h0);
        cycle();
        cycle();

        // Dependency through rt only (store/R-type source)
        setId(1'b1, CtrlLw, 5'd2, 5'd11, 5'd0, 1'b0, 32'h200, 32'h8);
        cycle();
        setId(1'b1, CtrlAdd, 5'd3, 5'd11, 5'd12, 1'b1, 32'h55, 32'h0);
        cycle();
        cycle();

        // No false stall: load into $0 read by rs=0
        setId(1'b1, CtrlLw, 5'd2, 5'd0, 5'd0, 1'b0, 32'h300, 32'hC);
        cycle();
        setId(1'b1, CtrlAdd, 5'd0, 5'd0, 5'd5, 1'b1, 32'h66, 32'h0);
        cycle();

        // No false stall: addi whose rt matches but rt is not a source
        setId(1'b1, CtrlLw, 5'd2, 5'd8, 5'd0, 1'b0, 32'h400, 32'h10);
        cycle();
        setId(1'b1, CtrlAddi, 5'd1, 5'd8, 5'd0, 1'b0, 32'h12, 32'h7);
        cycle();

        // Flush together with hazard: no stall, bubble, counter unchanged
        setId(1'b1, CtrlLw, 5'd2, 5'd8, 5'd0, 1'b0, 32'h500, 32'h14);
        cycle();
        setId(1'b1, CtrlAdd, 5'd8, 5'd2, 5'd6, 1'b1, 32'h88, 32'h0);
        flush = 1'b1;
        cycle();
        flush = 1'b0;

        // Unknown opcode as all-zero ctrl passes as a valid no-op; invalid slot forces ctrl 0
        setId(1'b1, '0, 5'd7, 5'd9, 5'd10, 1'b0, 32'hDEAD, 32'hBEEF);
        cycle();
        setId(1'b0, CtrlAdd, 5'd7, 5'd9, 5'd10, 1'b1, 32'h1, 32'h2);
        cycle();

        // Saturation: four more load-use pairs on a 2-bit counter
        for (int i = 0; i < 4; i++) begin
            setId(1'b1, CtrlLw, 5'd2, 5'd8, 5'd0, 1'b0, 32'h600 + 32'(i), 32'h18);
            cycle();
            setId(1'b1, CtrlAdd, 5'd8, 5'd2, 5'd13, 1'b1, 32'h99, 32'h0);
            cycle();
            cycle();
        end
        chk("stall_cnt_saturated", 64'(stallCnt), 64'd3);

        // Asynchronous reset mid-run with a valid EX slot
        chk("pre_reset_valid", 64'(exValid), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        chkAllZero("reset_async");
        mValid = 1'b0; mCtrl = '0; mRt = '0; mCnt = '0;
        @(negedge clk);
        reset = 1'b1;

        setId(1'b1, CtrlAddi, 5'd4, 5'd14, 5'd0, 1'b0, 32'h20, 32'h1);
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: observed no completion expected finish before 50000");
        $fatal(1, "timeout");
    end

endmodule
